// File: rtl/yblock_cfg_loader.sv
// Yellow-cell config loader: shifts BLOCKHEIGHT rows into the array with setup/strobe/hold timing, optional clear first.
// One row per 1+2*SETUP_CYCLES+PULSE_CYCLES cycles; row_ready stalls the source. YBLOCK_CFG_READBACK_EN enables rb_* readback.
module yblock_cfg_loader #(
   parameter int BLOCKWIDTH   = 8,
   parameter int BLOCKHEIGHT  = 8,
   parameter int SETUP_CYCLES = 2,
   parameter int PULSE_CYCLES = 2,
   parameter int CLEAR_CYCLES = 4
) (
   input  logic                    confclk,
   input  logic                    reset_n,
   input  logic                    start,
   input  logic                    clear_first,
   input  logic                    abort,
   input  logic                    row_valid,
   output logic                    row_ready,
   input  logic [4*BLOCKWIDTH-1:0] row_data,
   output logic                    busy,
   output logic                    done,
   output logic                    arr_reset,
   output logic                    arr_confclk,
   output logic [4*BLOCKWIDTH-1:0] arr_cbit,
   input  logic [4*BLOCKWIDTH-1:0] arr_cbitout,
   output logic                    rb_valid,
   output logic [4*BLOCKWIDTH-1:0] rb_data
);

   localparam int MAXC_SP = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
   localparam int MAXC    = (MAXC_SP > CLEAR_CYCLES) ? MAXC_SP : CLEAR_CYCLES;
   localparam int DW      = $clog2(MAXC + 1);
   localparam int RW      = $clog2(BLOCKHEIGHT + 1);

   typedef enum logic [2:0] {
      IDLE, CLEAR, WAIT_ROW, SETUP, STROBE, HOLD, DONE
   } state_t;

   state_t         state, state_nxt;
   logic [DW-1:0]  dur, dur_nxt;
   logic [RW-1:0]  row_cnt, row_cnt_nxt;
   logic           load_row;

   always_comb begin
      state_nxt   = state;
      dur_nxt     = dur + DW'(1);
      row_cnt_nxt = row_cnt;
      load_row    = 1'b0;
      case (state)
         IDLE: begin
            dur_nxt = '0;
            if (start) begin
               row_cnt_nxt = '0;
               state_nxt   = clear_first ? CLEAR : WAIT_ROW;
            end
         end
         CLEAR: if (dur == DW'(CLEAR_CYCLES - 1)) begin
            state_nxt = WAIT_ROW;
            dur_nxt   = '0;
         end
         WAIT_ROW: begin
            dur_nxt = '0;
            if (row_valid) begin
               load_row  = 1'b1;
               state_nxt = SETUP;
            end
         end
         SETUP: if (dur == DW'(SETUP_CYCLES - 1)) begin
            state_nxt = STROBE;
            dur_nxt   = '0;
         end
         STROBE: if (dur == DW'(PULSE_CYCLES - 1)) begin
            state_nxt = HOLD;
            dur_nxt   = '0;
         end
         HOLD: if (dur == DW'(SETUP_CYCLES - 1)) begin
            dur_nxt     = '0;
            row_cnt_nxt = row_cnt + RW'(1);
            state_nxt   = (row_cnt_nxt == RW'(BLOCKHEIGHT)) ? DONE : WAIT_ROW;
         end
         DONE: begin
            dur_nxt   = '0;
            state_nxt = IDLE;
         end
         default: begin
            dur_nxt   = '0;
            state_nxt = IDLE;
         end
      endcase
      // abort wins over a same-cycle handshake or timer expiry; arr_cbit is left as-is
      if (abort && state != IDLE) begin
         state_nxt   = IDLE;
         dur_nxt     = '0;
         row_cnt_nxt = '0;
         load_row    = 1'b0;
      end
   end

   // outputs are decoded from the next state so each one is a flop aligned with its state
   always_ff @(posedge confclk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         dur         <= '0;
         row_cnt     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         row_ready   <= 1'b0;
         arr_reset   <= 1'b0;
         arr_confclk <= 1'b0;
         arr_cbit    <= '0;
      end else begin
         state       <= state_nxt;
         dur         <= dur_nxt;
         row_cnt     <= row_cnt_nxt;
         busy        <= (state_nxt != IDLE);
         done        <= (state_nxt == DONE);
         row_ready   <= (state_nxt == WAIT_ROW);
         arr_reset   <= (state_nxt == CLEAR);
         arr_confclk <= (state_nxt == STROBE);
         if (load_row) arr_cbit <= row_data;
      end
   end

`ifdef YBLOCK_CFG_READBACK_EN
   logic rb_cap;

   // capture before the strobe falls: the array shifts on the falling edge of arr_confclk
   assign rb_cap = (state == STROBE) && (state_nxt == HOLD);

   always_ff @(posedge confclk or negedge reset_n) begin
      if (!reset_n) begin
         rb_valid <= 1'b0;
         rb_data  <= '0;
      end else begin
         rb_valid <= rb_cap;
         if (rb_cap) rb_data <= arr_cbitout;
      end
   end
`else
   logic unused_cbitout;

   assign unused_cbitout = ^arr_cbitout;
   assign rb_valid       = 1'b0;
   assign rb_data        = '0;
`endif

endmodule

// File: tb/tb_yblock_cfg_loader.sv
// Bench for yblock_cfg_loader (BLOCKWIDTH=2, BLOCKHEIGHT=3): scoreboarded strobe data, timing, abort, reset, readback.
module tb_yblock_cfg_loader;

   logic       confclk = 1'b0;
   logic       reset_n;
   logic       start, clear_first, abort, row_valid;
   logic [7:0] row_data;
   logic       row_ready, busy, done, arr_reset, arr_confclk, rb_valid;
   logic [7:0] arr_cbit, arr_cbitout, rb_data;

   int         total = 0;
   int         bad   = 0;
   int         strobes = 0, clears = 0, done_cnt = 0, rb_cnt = 0;
   int         cf_len = 0, ar_len = 0;
   bit         cf_prev = 0, ar_prev = 0, done_prev = 0;
   bit         rb_seen = 0, rb_chk = 0, preload = 0;
   logic [7:0] cb_at_rise;
   logic [7:0] exp_q[$];
   logic [7:0] rb_q[$];
   logic [7:0] amodel [0:2];
   logic       cf_d = 1'b0;

   yblock_cfg_loader #(
      .BLOCKWIDTH(2), .BLOCKHEIGHT(3), .SETUP_CYCLES(2), .PULSE_CYCLES(2), .CLEAR_CYCLES(4)
   ) dut (
      .confclk(confclk), .reset_n(reset_n), .start(start), .clear_first(clear_first),
      .abort(abort), .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
      .busy(busy), .done(done), .arr_reset(arr_reset), .arr_confclk(arr_confclk),
      .arr_cbit(arr_cbit), .arr_cbitout(arr_cbitout), .rb_valid(rb_valid), .rb_data(rb_data)
   );

   always #5 confclk = ~confclk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // array model: shifts down on the falling edge of the strobe, bottom row drives arr_cbitout
   always @(posedge confclk) begin
      cf_d <= arr_confclk;
      if (preload) begin
         amodel[0] <= 8'hA1;
         amodel[1] <= 8'hB2;
         amodel[2] <= 8'hC3;
      end else if (cf_d && !arr_confclk) begin
         amodel[0] <= arr_cbit;
         amodel[1] <= amodel[0];
         amodel[2] <= amodel[1];
      end
   end
   assign arr_cbitout = amodel[2];

   always @(negedge confclk) begin
      if (!reset_n) begin
         cf_prev = 0; cf_len = 0; ar_prev = 0; ar_len = 0; done_prev = 0;
      end else begin
         if (rb_valid || rb_data != 8'h00) rb_seen = 1;
         if (rb_valid && rb_chk) begin
            rb_cnt++;
            chk("rb_timing", {30'b0, cf_prev, arr_confclk}, 32'd2);
            if (rb_q.size() == 0) chk("rb_extra", {31'b0, rb_valid}, 32'd0);
            else chk("rb_dat", {24'b0, rb_data}, {24'b0, rb_q.pop_front()});
         end
         if (arr_confclk) begin
            if (!cf_prev) begin
               strobes++;
               cb_at_rise = arr_cbit;
               if (exp_q.size() == 0) chk("sb_empty", {31'b0, arr_confclk}, 32'd0);
               else chk("strobe_dat", {24'b0, arr_cbit}, {24'b0, exp_q.pop_front()});
            end
            cf_len++;
         end else if (cf_prev) begin
            chk("strobe_w", cf_len, 2);
            chk("cbit_hold", {24'b0, arr_cbit}, {24'b0, cb_at_rise});
            cf_len = 0;
         end
         if (arr_reset) begin
            if (!ar_prev) clears++;
            ar_len++;
         end else if (ar_prev) begin
            chk("clear_w", ar_len, 4);
            ar_len = 0;
         end
         if (done) done_cnt++;
         if (done_prev) chk("done_then_idle", {30'b0, busy, done}, 32'd0);
         cf_prev = arr_confclk; ar_prev = arr_reset; done_prev = done;
      end
   end

   task automatic tick();
      @(negedge confclk);
      #1;
   endtask

   task automatic kick(input logic c);
      start = 1'b1; clear_first = c;
      tick();
      start = 1'b0; clear_first = 1'b0;
      chk("busy_on_start", {31'b0, busy}, 32'd1);
   endtask

   task automatic send_row(input logic [7:0] d);
      int n;
      n = 0;
      row_valid = 1'b1; row_data = d;
      while (!row_ready && n < 50) begin tick(); n++; end
      if (!row_ready) begin
         chk("rdy_timeout", {31'b0, row_ready}, 32'd1);
         row_valid = 1'b0;
         return;
      end
      exp_q.push_back(d);
      tick();
      row_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int d0, n;
      d0 = done_cnt; n = 0;
      while (done_cnt == d0 && n < 100) begin tick(); n++; end
      chk(tag, done_cnt - d0, 1);
      tick(); tick();
      chk("sb_drain", exp_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      int s0, d0, c0, n, err, lat;
      reset_n = 1'b0; start = 0; clear_first = 0; abort = 0; row_valid = 0; row_data = '0;
      #3;
      chk("rst_ctl", {26'b0, busy, done, row_ready, arr_reset, arr_confclk, rb_valid}, 32'd0);
      chk("rst_cbit", {24'b0, arr_cbit}, 32'd0);
      chk("rst_rb", {24'b0, rb_data}, 32'd0);
      tick(); tick();
      reset_n = 1'b1;
      tick();

      // clear then three immediate rows
      s0 = strobes; c0 = clears;
      kick(1'b1);
      chk("clear_on", {31'b0, arr_reset}, 32'd1);
      send_row(8'h11); send_row(8'h22); send_row(8'h33);
      wait_done("done_clr_load");
      chk("clr_pulses", clears - c0, 1);
      chk("strobes_3", strobes - s0, 3);

      // ready latency, then a 10-cycle stall in WAIT_ROW
      kick(1'b0);
      send_row(8'h44);
      lat = 1;
      while (!row_ready && lat < 50) begin tick(); lat++; end
      chk("ready_lat", lat, 7);
      err = 0;
      for (int i = 0; i < 10; i++) begin
         if (!row_ready || arr_confclk) err++;
         tick();
      end
      chk("stall", err, 0);
      send_row(8'h55); send_row(8'h66);
      wait_done("done_stall");

      // abort in the second strobe cycle of row 2
      kick(1'b0);
      send_row(8'h71); send_row(8'h72);
      n = 0;
      while (!arr_confclk && n < 20) begin tick(); n++; end
      tick();
      d0 = done_cnt;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_cf", {31'b0, arr_confclk}, 32'd0);
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_cbit", {24'b0, arr_cbit}, 32'h72);
      repeat (5) tick();
      chk("abort_nodone", done_cnt - d0, 0);
      s0 = strobes;
      kick(1'b0);
      send_row(8'h81); send_row(8'h82); send_row(8'h83);
      wait_done("done_after_abort");
      chk("strobes_after_abort", strobes - s0, 3);

      // start pulsed while busy is ignored
      c0 = clears;
      kick(1'b0);
      send_row(8'h91);
      start = 1'b1; clear_first = 1'b1;
      tick();
      start = 1'b0; clear_first = 1'b0;
      send_row(8'h92); send_row(8'h93);
      wait_done("done_busy_start");
      chk("no_restart_clr", clears - c0, 0);

      // reset in the middle of a strobe, start on the first edge after release
      kick(1'b0);
      send_row(8'h5A);
      n = 0;
      while (!arr_confclk && n < 20) begin tick(); n++; end
      #2 reset_n = 1'b0;
      #1;
      chk("rst_mid_cf", {31'b0, arr_confclk}, 32'd0);
      chk("rst_mid_ctl", {26'b0, busy, done, row_ready, arr_reset, arr_confclk, rb_valid}, 32'd0);
      chk("rst_mid_cbit", {24'b0, arr_cbit}, 32'd0);
      tick(); tick();
      exp_q.delete();
      reset_n = 1'b1;
      kick(1'b0);
      send_row(8'hE1); send_row(8'hE2); send_row(8'hE3);
      wait_done("done_after_rst");

`ifdef YBLOCK_CFG_READBACK_EN
      preload = 1'b1;
      tick();
      preload = 1'b0;
      rb_q.push_back(8'hC3); rb_q.push_back(8'hB2); rb_q.push_back(8'hA1);
      rb_chk = 1'b1; rb_cnt = 0;
      kick(1'b0);
      send_row(8'hD4); send_row(8'hE5); send_row(8'hF6);
      wait_done("done_readback");
      rb_chk = 1'b0;
      chk("rb_pulses", rb_cnt, 3);
      chk("rb_drain", rb_q.size(), 0);
`else
      chk("rb_quiet", {31'b0, rb_seen}, 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/yblock_cfg_loader.md
YBLOCK_CFG_LOADER -- requirements
Module: yblock_cfg_loader

Interface
REQ-001 SHALL have parameter BLOCKWIDTH, default 8: columns of the target yellow-cell array; each column takes 4 config bits.
REQ-002 SHALL have parameter BLOCKHEIGHT, default 8: rows shifted per load.
REQ-003 SHALL have parameter SETUP_CYCLES, default 2: cycles arr_cbit is stable before the strobe rises and after it falls.
REQ-004 SHALL have parameter PULSE_CYCLES, default 2: cycles arr_confclk stays high per row.
REQ-005 SHALL have parameter CLEAR_CYCLES, default 4: cycles arr_reset stays high during a pre-load clear.
REQ-006 SHALL have one clock and an asynchronous, active-low reset; reset_n asserted (0) forces state immediately, with no clock edge needed.
REQ-007 SHALL have these ports (name, direction, width, meaning):
- confclk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  begin a load; sampled only in IDLE.
- clear_first  in  1  sampled with start; 1 = clear the array before shifting.
- abort  in  1  abandon the current load.
- row_valid  in  1  row_data is valid.
- row_ready  out  1  loader accepts a row this cycle.
- row_data  in  4*BLOCKWIDTH  one configuration row.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a load completes.
- arr_reset  out  1  active-high freeze/clear to the array.
- arr_confclk  out  1  configuration strobe to the array.
- arr_cbit  out  4*BLOCKWIDTH  top-row config bits to the array.
- arr_cbitout  in  4*BLOCKWIDTH  bottom-row config bits from the array.
- rb_valid  out  1  readback row valid, one-cycle pulse.
- rb_data  out  4*BLOCKWIDTH  readback row.

Function
REQ-008 All outputs SHALL be registered.
REQ-009 The FSM SHALL have states IDLE, CLEAR, WAIT_ROW, SETUP, STROBE, HOLD and DONE.
REQ-010 In IDLE with start=1, the FSM SHALL clear the row counter and go to CLEAR if clear_first=1, otherwise to WAIT_ROW.
REQ-011 CLEAR SHALL hold arr_reset=1 for exactly CLEAR_CYCLES cycles, then go to WAIT_ROW; arr_reset SHALL be 0 in every other state.
REQ-012 WAIT_ROW SHALL drive row_ready=1; row_ready SHALL be 0 in every other state.
REQ-013 When row_valid and row_ready are both 1, the FSM SHALL latch row_data into arr_cbit and go to SETUP.
REQ-014 SETUP SHALL last SETUP_CYCLES cycles.
REQ-015 STROBE SHALL hold arr_confclk=1 for PULSE_CYCLES cycles.
REQ-016 HOLD SHALL last SETUP_CYCLES cycles with arr_confclk=0.
REQ-017 At the end of HOLD the row counter SHALL increment; at BLOCKHEIGHT the FSM goes to DONE, otherwise to WAIT_ROW.
REQ-018 arr_cbit SHALL stay unchanged from the row handshake until the next handshake.
REQ-019 With default parameters, row_ready SHALL reassert 7 cycles after the handshake cycle (1+2*SETUP_CYCLES+PULSE_CYCLES).
REQ-020 Rows shift downward, so the first accepted row SHALL end in the bottom row; callers supply the bottom row first.
REQ-021 DONE SHALL drive done=1 for one cycle, then go to IDLE; busy SHALL fall in that same next cycle.
REQ-022 start SHALL be ignored while busy=1.
REQ-023 abort=1 in any non-IDLE state SHALL send the FSM to IDLE on the next edge: arr_confclk=0, arr_reset=0, row counter=0, no done pulse; arr_cbit keeps its value.
REQ-024 abort SHALL take priority over a simultaneous row handshake or state-duration expiry.
REQ-025 A stalled row_valid SHALL hold the FSM in WAIT_ROW indefinitely with no strobe.
REQ-026 The row counter SHALL be $clog2(BLOCKHEIGHT+1) bits wide and SHALL never wrap.

Reset
REQ-027 With reset_n=0, the FSM SHALL be in IDLE and every output SHALL be 0 (including arr_cbit and rb_data), asynchronously, even mid-strobe.
REQ-028 The first possible start SHALL be on the first rising edge after reset_n deasserts.

Configuration
REQ-029 Macro YBLOCK_CFG_READBACK_EN, when defined: on the last cycle of each STROBE, arr_cbitout SHALL be captured into rb_data, with rb_valid=1 in the first HOLD cycle; this returns the previous array contents bottom row first.
REQ-030 Macro YBLOCK_CFG_READBACK_EN, when not defined: rb_valid and rb_data SHALL be constant 0, and arr_cbitout SHALL remain a port but be unused.

Verification
REQ-031 reset_n=0 during STROBE SHALL drive arr_confclk and all outputs to 0 at once, with busy=0.
REQ-032 BLOCKWIDTH=2, BLOCKHEIGHT=3, clear_first=1, rows 8'h11/8'h22/8'h33 each offered immediately SHALL give arr_reset high 4 cycles, then 3 arr_confclk pulses 2 cycles high carrying 11,22,33, then one done pulse and busy low the next cycle.
REQ-033 row_valid held low 10 cycles in WAIT_ROW SHALL keep arr_confclk 0 and row_ready 1 throughout, then resume normally.
REQ-034 abort asserted in the second STROBE cycle of row 2 SHALL give arr_confclk=0 and busy=0 next cycle with no done; a following start SHALL strobe 3 rows again.
REQ-035 start pulsed while busy SHALL not restart or alter the row count.
REQ-036 With YBLOCK_CFG_READBACK_EN defined and an array model preloaded with rows A (top), B, C, loading D,E,F SHALL give rb_data C, B, A on three rb_valid pulses.
